// File: rtl/avg_filter_multi_if.sv
// rtl/avg_filter_multi_if.sv - sample-in / result-out handshake bundle for avg_filter_multi
interface avg_filter_multi_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;

    // Sample source / codec side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Filter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/avg_filter_multi.sv
// rtl/avg_filter_multi.sv - per-channel N-point moving average with bypass and history clear
module avg_filter_multi #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int CHANNELS   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    avg_filter_multi_if.slave bus,
    input  logic              bypass,
    input  logic              clear,
    output logic              busy,
    output logic              primed
);
    localparam int N     = 1 << ADDR_WIDTH;
    localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;
    localparam logic [ADDR_WIDTH:0]   FILL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          clr_cnt;
    logic [ADDR_WIDTH-1:0]          wr_ptr;
    logic [ADDR_WIDTH:0]            fill;
    logic                           out_valid_q;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data_q;
    logic signed [ACC_W-1:0]        acc_q  [CHANNELS];
    logic signed [ACC_W-1:0]        acc_nx [CHANNELS];
    logic signed [ACC_W-1:0]        x_ext, old_ext;
    logic [CHANNELS*DATA_WIDTH-1:0] res_data;
    logic [DATA_WIDTH-1:0]          hist [CHANNELS][N];
    logic                           accept;
    logic                           run_clear;

    // A clear request wins over a same-cycle sample so no accepted sample is silently discarded
    assign bus.in_ready  = (state_q == ST_RUN) && !clear && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign run_clear     = (state_q == ST_RUN) && clear;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q == ST_CLEAR);
    assign primed        = (fill == FILL_FULL);

    // Next state: leave CLEAR after zeroing the last entry unless a new clear restarts the pass
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (!clear && clr_cnt == LAST_IDX) state_d = ST_RUN;
            ST_RUN:   if (clear) state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Per-lane running sum update and the value presented on accept
    always_comb begin
        res_data = '0;
        x_ext    = '0;
        old_ext  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            x_ext   = {{ADDR_WIDTH{bus.in_data[k*DATA_WIDTH + DATA_WIDTH-1]}},
                       bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]};
            old_ext = {{ADDR_WIDTH{hist[k][wr_ptr][DATA_WIDTH-1]}}, hist[k][wr_ptr]};
            acc_nx[k] = acc_q[k] + x_ext - old_ext;
            res_data[k*DATA_WIDTH +: DATA_WIDTH] = bypass ? bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]
                                                          : acc_nx[k][ADDR_WIDTH +: DATA_WIDTH];
        end
    end

    // State, pointers, accumulators and the single output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt     <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR)
                clr_cnt <= clear ? '0 : clr_cnt + ADDR_WIDTH'(1);
            if (run_clear) begin
                clr_cnt     <= '0;
                wr_ptr      <= '0;
                fill        <= '0;
                out_valid_q <= 1'b0;
                for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
            end else if (accept) begin
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
                if (fill != FILL_FULL) fill <= fill + (ADDR_WIDTH+1)'(1);
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                for (int k = 0; k < CHANNELS; k++) acc_q[k] <= acc_nx[k];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // History store has no reset; the CLEAR pass zeroes it one index per cycle
    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (state_q == ST_CLEAR)
                hist[k][clr_cnt] <= '0;
            else if (accept)
                hist[k][wr_ptr] <= bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: tb/tb_avg_filter_multi.sv
// tb/tb_avg_filter_multi.sv - directed table-driven bench for avg_filter_multi
module tb_avg_filter_multi;
    localparam int DW = 24;
    localparam int AW = 3;
    localparam int CH = 2;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    logic bypass;
    logic clear;
    logic busy;
    logic primed;

    int total = 0;
    int bad   = 0;

    avg_filter_multi_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

    avg_filter_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) dut (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .bypass  (bypass),
        .clear   (clear),
        .busy    (busy),
        .primed  (primed)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic vld;
        logic byp;
        logic ordy;
        int   d0;
        int   d1;
        logic e_rdy;
        logic e_vld;
        int   e0;
        int   e1;
        logic e_prim;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic vld, logic byp, logic ordy, int d0, int d1,
                                logic e_rdy, logic e_vld, int e0, int e1, logic e_prim);
        vec_t v;
        v.vld = vld; v.byp = byp; v.ordy = ordy; v.d0 = d0; v.d1 = d1;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e0 = e0; v.e1 = e1; v.e_prim = e_prim;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic run_table(input string tag);
        logic [DW-1:0] e0, e1;
        for (int i = 0; i < tbl.size(); i++) begin
            bus.in_valid  = tbl[i].vld;
            bypass        = tbl[i].byp;
            bus.out_ready = tbl[i].ordy;
            e0 = tbl[i].e0[DW-1:0];
            e1 = tbl[i].e1[DW-1:0];
            bus.in_data   = {tbl[i].d1[DW-1:0], tbl[i].d0[DW-1:0]};
            #1;
            check($sformatf("%s[%0d] in_ready", tag, i), {31'b0, bus.in_ready}, {31'b0, tbl[i].e_rdy});
            tick();
            check($sformatf("%s[%0d] out_valid", tag, i), {31'b0, bus.out_valid}, {31'b0, tbl[i].e_vld});
            check($sformatf("%s[%0d] primed", tag, i), {31'b0, primed}, {31'b0, tbl[i].e_prim});
            if (tbl[i].e_vld) begin
                check($sformatf("%s[%0d] lane0", tag, i), {8'b0, bus.out_data[DW-1:0]}, {8'b0, e0});
                check($sformatf("%s[%0d] lane1", tag, i), {8'b0, bus.out_data[2*DW-1:DW]}, {8'b0, e1});
            end
        end
        tbl.delete();
        bus.in_valid = 1'b0;
        bypass       = 1'b0;
    endtask

    task automatic clear_wait(input string tag, input logic ordy);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        clear         = 1'b1;
        tick();
        clear         = 1'b0;
        check({tag, " out_valid dropped"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, " primed cleared"}, {31'b0, primed}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s busy[%0d]", tag, i), {31'b0, busy}, 32'd1);
            check($sformatf("%s in_ready low[%0d]", tag, i), {31'b0, bus.in_ready}, 32'd0);
            tick();
        end
        check({tag, " busy done"}, {31'b0, busy}, 32'd0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        longint acc;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bypass        = 1'b0;
        clear         = 1'b0;
        tick();
        tick();
        check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst out_data", bus.out_data[31:0], 32'd0);
        check("rst in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd1);
        check("rst primed", {31'b0, primed}, 32'd0);

        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("init busy[%0d]", i), {31'b0, busy}, 32'd1);
            check($sformatf("init in_ready[%0d]", i), {31'b0, bus.in_ready}, 32'd0);
            tick();
        end
        check("init busy done", {31'b0, busy}, 32'd0);
        check("init in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("init out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("init primed", {31'b0, primed}, 32'd0);

        // Constant ramp-up, then backpressure hold, release and drain
        for (int i = 1; i <= 9; i++)
            add(1, 0, 1, 800, -800, 1, 1, 100 * (i > 8 ? 8 : i), -100 * (i > 8 ? 8 : i), i >= 8);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 1600, 0, 0, 1, 800, -800, 1);
        add(1, 0, 1, 1600, 0, 1, 1, 900, -700, 1);
        add(1, 0, 1, 1600, 0, 1, 1, 1000, -600, 1);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        run_table("const");

        // Clear mid-stream with a result pending
        clear_wait("clr0", 1'b1);
        for (int i = 1; i <= 5; i++)
            add(1, 0, 1, 800, 0, 1, 1, 100 * i, 0, 0);
        run_table("pre");
        clear_wait("clr1", 1'b0);
        add(1, 0, 1, 800, 0, 1, 1, 100, 0, 0);
        run_table("post");

        // Bypass keeps history running
        clear_wait("clr2", 1'b1);
        for (int i = 1; i <= 8; i++)
            add(1, 1, 1, 1000 * i, -5, 1, 1, 1000 * i, -5, i == 8);
        add(1, 0, 1, 9000, -5, 1, 1, 5500, -5, 1);
        run_table("byp");

        // Full-scale positive window, then swing to full-scale negative
        clear_wait("clr3", 1'b1);
        for (int i = 1; i <= 8; i++) begin
            acc = longint'(i) * 64'sd8388607;
            add(1, 0, 1, 8388607, 0, 1, 1, int'(acc >>> 3), 0, i == 8);
        end
        for (int j = 1; j <= 8; j++) begin
            acc = longint'(8 - j) * 64'sd8388607 - longint'(j) * 64'sd8388608;
            add(1, 0, 1, -8388608, 0, 1, 1, int'(acc >>> 3), 0, 1);
        end
        run_table("ext");

        // Floor rounding: one -1 stays visible for a full window
        clear_wait("clr4", 1'b1);
        add(1, 0, 1, -1, 1, 1, 1, -1, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(1, 0, 1, 0, 0, 1, 1, (i < 8) ? -1 : 0, 0, i >= 7);
        run_table("neg1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
